boolean: RTL and testbench



---
 rtl/boolean.sv | 50 +++++
 tb/tb_boolean.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/boolean.sv
// Three-input programmable Boolean function unit: {A,B,C} selects one bit of an
// 8-bit run-time reloadable truth table, driven combinationally on F and registered on F_q.
module boolean #(
   parameter logic [7:0] TT_RESET   = 8'hE8,
   parameter bit         REG_OUT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       tt_we,
   input  logic [7:0] tt_wdata,
   output logic       F,
   output logic       F_q,
   output logic [7:0] tt
);

   logic [2:0] tt_idx;

   assign tt_idx = {A, B, C};

   // The table is only ever loaded from tt_wdata, so an unknown index can
   // at worst make F unknown; it never reaches the table storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tt <= TT_RESET;
      end else if (tt_we) begin
         tt <= tt_wdata;
      end
   end

   assign F = tt[tt_idx];

   generate
      if (REG_OUT_EN) begin : g_reg_out
         // Samples F from before the edge, so a same-edge write shows up one edge later.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               F_q <= 1'b0;
            end else begin
               F_q <= F;
            end
         end
      end else begin : g_comb_out
         assign F_q = F;
      end
   endgenerate

endmodule

// File: tb/tb_boolean.sv
// Directed, table-driven self-checking bench for the boolean function unit.
module tb_boolean;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst;
   logic       A, B, C;
   logic       tt_we;
   logic [7:0] tt_wdata;
   logic       F, F_q;
   logic [7:0] tt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] abc;
      logic       exp_f;
   } vec_t;

   vec_t maj_vec[8];
   vec_t xor_vec[8];

   boolean #(.TT_RESET(8'hE8), .REG_OUT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
      .tt_we(tt_we), .tt_wdata(tt_wdata), .F(F), .F_q(F_q), .tt(tt)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_abc(input logic [2:0] v);
      {A, B, C} = v;
   endtask

   task automatic run_vectors(input string name, input vec_t v[8]);
      for (int i = 0; i < 8; i++) begin
         set_abc(v[i].abc);
         #1;
         check($sformatf("%s idx%0d", name, i), {7'd0, F}, {7'd0, v[i].exp_f});
      end
   endtask

   initial begin
      logic [7:0] exp_tt;
      logic [2:0] r_abc;

      maj_vec[0] = '{3'd0, 1'b0}; maj_vec[1] = '{3'd1, 1'b0};
      maj_vec[2] = '{3'd2, 1'b0}; maj_vec[3] = '{3'd3, 1'b1};
      maj_vec[4] = '{3'd4, 1'b0}; maj_vec[5] = '{3'd5, 1'b1};
      maj_vec[6] = '{3'd6, 1'b1}; maj_vec[7] = '{3'd7, 1'b1};
      xor_vec[0] = '{3'd0, 1'b0}; xor_vec[1] = '{3'd1, 1'b1};
      xor_vec[2] = '{3'd2, 1'b1}; xor_vec[3] = '{3'd3, 1'b0};
      xor_vec[4] = '{3'd4, 1'b1}; xor_vec[5] = '{3'd5, 1'b0};
      xor_vec[6] = '{3'd6, 1'b0}; xor_vec[7] = '{3'd7, 1'b1};

      // Reset with clock held idle
      rst = 1'b1; tt_we = 1'b0; tt_wdata = 8'h00;
      set_abc(3'b001);
      #2;
      check("reset tt", tt, 8'hE8);
      check("reset F_q", {7'd0, F_q}, 8'h00);
      rst = 1'b0;
      #5;
      check("idle F abc=001", {7'd0, F}, 8'h00);
      run_vectors("maj", maj_vec);

      // Table reload to XOR3
      clk_en = 1'b1;
      @(negedge clk);
      set_abc(3'b001);
      tt_we = 1'b1; tt_wdata = 8'h96;
      #1;
      check("F before write edge", {7'd0, F}, 8'h00);
      @(posedge clk); #1;
      tt_we = 1'b0;
      check("reload tt", tt, 8'h96);
      check("reload F abc=001", {7'd0, F}, 8'h01);
      set_abc(3'b110); #1;
      check("reload F abc=110", {7'd0, F}, 8'h00);
      run_vectors("xor3", xor_vec);

      // Registered path: restore majority, park F_q at 0
      @(negedge clk);
      tt_we = 1'b1; tt_wdata = 8'hE8; set_abc(3'b000);
      @(posedge clk);
      @(negedge clk);
      tt_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("F_q parked", {7'd0, F_q}, 8'h00);
      set_abc(3'b111); #1;
      check("reg F immediate", {7'd0, F}, 8'h01);
      check("reg F_q before edge", {7'd0, F_q}, 8'h00);
      @(posedge clk); #1;
      check("reg F_q after edge", {7'd0, F_q}, 8'h01);

      // Simultaneous write and capture
      @(negedge clk);
      set_abc(3'b011);
      tt_we = 1'b1; tt_wdata = 8'h00;
      #1;
      check("simul F pre", {7'd0, F}, 8'h01);
      @(posedge clk); #1;
      tt_we = 1'b0;
      check("simul F_q old table", {7'd0, F_q}, 8'h01);
      check("simul F new table", {7'd0, F}, 8'h00);
      check("simul tt", tt, 8'h00);
      @(posedge clk); #1;
      check("simul F_q next edge", {7'd0, F_q}, 8'h00);

      // Async reset mid-operation
      @(negedge clk);
      tt_we = 1'b1; tt_wdata = 8'h96; set_abc(3'b001);
      @(posedge clk);
      @(negedge clk);
      tt_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("pre-reset tt", tt, 8'h96);
      check("pre-reset F_q", {7'd0, F_q}, 8'h01);
      #2;
      tt_we = 1'b1; tt_wdata = 8'h55; rst = 1'b1;
      #1;
      check("async rst tt", tt, 8'hE8);
      check("async rst F_q", {7'd0, F_q}, 8'h00);
      @(posedge clk);
      @(posedge clk); #1;
      check("rst holds over tt_we", tt, 8'hE8);
      check("rst holds F_q", {7'd0, F_q}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("first write after rst", tt, 8'h55);
      tt_we = 1'b0;

      // Hold: random wdata without tt_we
      exp_tt = 8'h55;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tt_wdata = 8'($urandom);
         r_abc = 3'($urandom_range(7, 0));
         set_abc(r_abc);
         @(posedge clk); #1;
         check($sformatf("hold tt cyc%0d", i), tt, exp_tt);
         check($sformatf("hold F cyc%0d", i), {7'd0, F}, {7'd0, exp_tt[r_abc]});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule
